// File: rtl/sid_pot_ctrl_pkg.sv
// Shared types for the SID paddle (POTX/POTY) measurement block.
package sid_pot_ctrl_pkg;

    typedef logic [7:0] reg8_t;
    typedef logic [8:0] reg9_t;

    typedef struct packed {
        logic [1:0] charged;
    } pot_i_t;

    typedef struct packed {
        logic discharge;
    } pot_o_t;

    typedef struct packed {
        reg8_t [1:0] xy;
    } pot_reg_t;

    typedef enum logic {
        POT_DISCHARGE = 1'b0,
        POT_CHARGE    = 1'b1
    } pot_state_e;

endpackage

// File: rtl/sid_pot_channel.sv
// One paddle axis: charge-time counter, sticky detect flag and result latch.
// Optional SID_POT_SYNC_EN adds a 2-flop synchronizer on the comparator input.
module sid_pot_channel
    import sid_pot_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  start,
    input  logic  count_en,
    input  logic  latch_en,
    input  logic  charged,
    output reg8_t result
);

    logic  charged_s;
    reg8_t value;
    logic  done;

`ifdef SID_POT_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], charged};
        end
    end

    assign charged_s = sync_ff[1];
`else
    assign charged_s = charged;
`endif

    // Detection is sticky until the next discharge so late comparator glitches are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (clr) begin
            value  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            if (start) begin
                value <= '0;
                done  <= 1'b0;
            end else if (count_en && !done) begin
                if (charged_s) begin
                    done <= 1'b1;
                end else begin
                    value <= value + 8'd1;
                end
            end
            if (latch_en) begin
                result <= value;
            end
        end
    end

endmodule

// File: rtl/sid_pot_ctrl.sv
// SID paddle sequencer: discharge window, then charge-timing window per cycle_en strobe.
// Build option SID_POT_SYNC_EN enables input synchronizers inside each channel.
module sid_pot_ctrl
    import sid_pot_ctrl_pkg::*;
#(
    parameter int DISCHARGE_LEN = 256,
    parameter int COUNT_LEN     = 256
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     cycle_en,
    input  logic     res,
    input  pot_i_t   pot_i,
    output pot_o_t   pot_o,
    output pot_reg_t pot,
    output logic     sample_valid
);

    localparam reg9_t DIS_LAST = reg9_t'(DISCHARGE_LEN - 1);
    localparam reg9_t CNT_LAST = reg9_t'(COUNT_LEN - 1);

    pot_state_e state, state_nxt;
    reg9_t      cnt, cnt_nxt;
    logic       ch_start, ch_count, ch_latch;
    reg8_t      ch_result [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= POT_DISCHARGE;
            cnt          <= '0;
            sample_valid <= 1'b0;
        end else if (res) begin
            state        <= POT_DISCHARGE;
            cnt          <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sample_valid <= ch_latch;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        ch_start        = 1'b0;
        ch_count        = 1'b0;
        ch_latch        = 1'b0;
        pot_o.discharge = (state == POT_DISCHARGE);
        if (cycle_en) begin
            case (state)
                POT_DISCHARGE: begin
                    if (cnt == DIS_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = POT_CHARGE;
                        ch_start  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 9'd1;
                    end
                end
                POT_CHARGE: begin
                    // The last strobe of the window only publishes; it never counts.
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = POT_DISCHARGE;
                        ch_latch  = 1'b1;
                    end else begin
                        cnt_nxt  = cnt + 9'd1;
                        ch_count = 1'b1;
                    end
                end
                default: state_nxt = POT_DISCHARGE;
            endcase
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        sid_pot_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (res),
            .start    (ch_start),
            .count_en (ch_count),
            .latch_en (ch_latch),
            .charged  (pot_i.charged[i]),
            .result   (ch_result[i])
        );
    end

    assign pot = {ch_result[1], ch_result[0]};

endmodule

// File: tb/tb_sid_pot_ctrl.sv
// Scoreboard bench for sid_pot_ctrl: cycle_en every 4 clk, expected results queued per period.
module tb_sid_pot_ctrl;
    import sid_pot_ctrl_pkg::*;

    logic     clk = 1'b0;
    logic     rst, cycle_en, res;
    pot_i_t   pot_i;
    pot_o_t   pot_o;
    pot_reg_t pot;
    logic     sample_valid;

    sid_pot_ctrl #(.DISCHARGE_LEN(256), .COUNT_LEN(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .cycle_en     (cycle_en),
        .res          (res),
        .pot_i        (pot_i),
        .pot_o        (pot_o),
        .pot          (pot),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q [$];
    int          strobe_idx = 0;
    int          sv_count   = 0;
    int          last_sv    = -1;
    int          prev_sv    = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        cycle_en = 1'b1;
        @(posedge clk);
        #1;
        cycle_en = 1'b0;
        strobe_idx++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Comparator level for charge strobe k: high from tx on, except inside [gl, gh).
    function automatic logic cval(input int tx, input int gl, input int gh, input int k);
        return (tx >= 0) && (k >= tx) && !((k >= gl) && (k < gh));
    endfunction

    // Reference count: first detection freezes the value; only strobes 0..254 count.
    function automatic int model(input int tx, input int gl, input int gh);
        int  v = 0;
        bit  d = 0;
        for (int k = 0; k < 255; k++) begin
            if (!d && cval(tx, gl, gh, k)) d = 1;
            else if (!d) v++;
        end
        return v;
    endfunction

    task automatic run_period(input int tx, input int gl, input int gh, input int ty);
        logic [7:0] ex, ey;
        ex = 8'(model(tx, gl, gh));
        ey = 8'(model(ty, 0, 0));
        exp_q.push_back({ey, ex});
        pot_i = '0;
        for (int k = 0; k < 256; k++) begin
            if (k == 0 || k == 255) check("discharge_hi", 32'(pot_o.discharge), 1);
            tick();
        end
        check("discharge_lo", 32'(pot_o.discharge), 0);
        for (int k = 0; k < 256; k++) begin
            pot_i.charged[0] = cval(tx, gl, gh, k);
            pot_i.charged[1] = cval(ty, 0, 0, k);
            tick();
        end
        pot_i = '0;
        check("discharge_back", 32'(pot_o.discharge), 1);
    endtask

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            logic [15:0] e;
            sv_count++;
            prev_sv = last_sv;
            last_sv = strobe_idx;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("potx", 32'(pot.xy[0]), 32'(e[7:0]));
                check("poty", 32'(pot.xy[1]), 32'(e[15:8]));
            end
        end
    end

    initial begin
        int sv_before;
        rst      = 1'b1;
        res      = 1'b0;
        cycle_en = 1'b0;
        pot_i    = '0;
        repeat (3) tick();
        check("rst_discharge", 32'(pot_o.discharge), 1);
        check("rst_pot", 32'(pot), 0);
        check("rst_valid", 32'(sample_valid), 0);
        rst = 1'b0;

        run_period(100, 0, 0, 37);
        run_period(100, 0, 0, 37);
        check("period_spacing", 32'(last_sv - prev_sv), 512);

        run_period(-1, 0, 0, 0);
        run_period(50, 51, 80, -1);

        // Soft reset in the middle of a charge window, coincident with a strobe.
        pot_i = '0;
        for (int k = 0; k < 256; k++) tick();
        for (int k = 0; k < 120; k++) begin
            pot_i.charged[0] = (k >= 10);
            tick();
        end
        sv_before = sv_count;
        res      = 1'b1;
        cycle_en = 1'b1;
        @(posedge clk);
        #1;
        res      = 1'b0;
        cycle_en = 1'b0;
        pot_i    = '0;
        check("res_pot", 32'(pot), 0);
        check("res_discharge", 32'(pot_o.discharge), 1);
        check("res_valid", 32'(sample_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        run_period(20, 0, 0, 200);
        check("res_one_sample", 32'(sv_count - sv_before), 1);

        run_period(int'($urandom_range(0, 300)), 0, 0, int'($urandom_range(0, 300)));

        repeat (10) @(posedge clk);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
